// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory master.
// Size encodings, FSM state encoding and per-size byte helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC1 = 2'd1,
    ACC2 = 2'd2,
    RESP = 2'd3
  } state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 4'd1;
      2'd1:    return 4'd2;
      2'd2:    return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response and data-memory signals of the load/store unit.
// master = the LSU itself, slave = pipeline plus memory model.
interface lsu_mem_master_if #(
  parameter int ADDR_WID = 29
) ();
  logic                req_valid;
  logic                req_ready;
  logic                req_we;
  logic [31:0]         req_addr;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [63:0]         req_wdata;
  logic                rsp_valid;
  logic [63:0]         rsp_rdata;
  logic                rsp_err;
  logic [ADDR_WID-1:0] mem_addr;
  logic [63:0]         mem_rdata;
  logic                mem_wr_en;
  logic [63:0]         mem_wdata;
  logic [7:0]          mem_wmask;

  modport master (
    input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr_en, mem_wdata, mem_wmask
  );

  modport slave (
    output req_valid, req_we, req_addr, req_size, req_signed, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wr_en, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane alignment: write masks, store-data shifting for both halves of an
// access, and load-data merge with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [63:0] wdata,
  input  logic [63:0] lo,
  input  logic [63:0] hi,
  output logic        split,
  output logic [15:0] mask16,
  output logic [63:0] wdata_lo,
  output logic [63:0] wdata_hi,
  output logic [63:0] load_data
);
  logic [5:0]  sh_s;
  logic [63:0] shifted_s;

  // Lane math shared by both memory cycles and the load result
  always_comb begin
    sh_s      = {off, 3'b000};
    split     = ({1'b0, off} + size_bytes(size)) > 4'd8;
    mask16    = {8'd0, size_mask(size)} << off;
    wdata_lo  = wdata << sh_s;
    if (off == 3'd0) begin
      wdata_hi = 64'd0;
    end else begin
      wdata_hi = wdata >> (7'd64 - {1'b0, sh_s});
    end
    shifted_s = 64'({hi, lo} >> sh_s);
    case (size_e'(size))
      SZ_B:    load_data = sign_ext ? {{56{shifted_s[7]}},  shifted_s[7:0]}  : {56'd0, shifted_s[7:0]};
      SZ_H:    load_data = sign_ext ? {{48{shifted_s[15]}}, shifted_s[15:0]} : {48'd0, shifted_s[15:0]};
      SZ_W:    load_data = sign_ext ? {{32{shifted_s[31]}}, shifted_s[31:0]} : {32'd0, shifted_s[31:0]};
      default: load_data = shifted_s;
    endcase
  end
endmodule

// File: rtl/lsu_mem_master.sv
// Load/store unit memory master: turns byte-addressed B/H/W/D requests into
// one or two dword memory cycles and returns extended load data.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int DATA_DEP = 512,
  parameter int ADDR_WID = 29
) (
  input logic               clk,
  input logic               nrst,
  lsu_mem_master_if.master  bus
);
  localparam logic [ADDR_WID:0] DEP_L = (ADDR_WID + 1)'(DATA_DEP);

  state_e              state_r, state_nxt_s;
  logic [31:0]         addr_r;
  logic [1:0]          size_r;
  logic                sgn_r, we_r, err_r;
  logic [63:0]         wdata_r, lo_r;

  logic [31:0]         cur_addr_s;
  logic [1:0]          cur_size_s;
  logic                cur_sgn_s, cur_we_s;
  logic [63:0]         cur_wdata_s, lo_in_s, hi_in_s;
  logic [ADDR_WID-1:0] idx1_s, idx2_s;
  logic                accept_s, split_s, range_err_s;
  logic [15:0]         mask16_s;
  logic [63:0]         wdata_lo_s, wdata_hi_s, load_s;

  logic [ADDR_WID-1:0] mem_addr_r;
  logic                mem_wr_en_r, rsp_valid_r, rsp_err_r;
  logic [7:0]          mem_wmask_r;
  logic [63:0]         mem_wdata_r, rsp_rdata_r;

  assign bus.req_ready = (state_r == IDLE);
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wr_en = mem_wr_en_r;
  assign bus.mem_wmask = mem_wmask_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

  // Operand select: live request while idle (to set up ACC1), latched one afterwards
  always_comb begin
    accept_s = bus.req_valid & (state_r == IDLE);
    if (state_r == IDLE) begin
      cur_addr_s  = bus.req_addr;
      cur_size_s  = bus.req_size;
      cur_sgn_s   = bus.req_signed;
      cur_we_s    = bus.req_we;
      cur_wdata_s = bus.req_wdata;
    end else begin
      cur_addr_s  = addr_r;
      cur_size_s  = size_r;
      cur_sgn_s   = sgn_r;
      cur_we_s    = we_r;
      cur_wdata_s = wdata_r;
    end
    if (state_r == ACC1) begin
      lo_in_s = bus.mem_rdata;
    end else begin
      lo_in_s = lo_r;
    end
    if (state_r == ACC2) begin
      hi_in_s = bus.mem_rdata;
    end else begin
      hi_in_s = 64'd0;
    end
    idx1_s      = ADDR_WID'(cur_addr_s[31:3]);
    idx2_s      = idx1_s + ADDR_WID'(1);
    range_err_s = ({1'b0, idx1_s} >= DEP_L) | (split_s & ({1'b0, idx2_s} >= DEP_L));
  end

  lsu_align u_align (
    .off       (cur_addr_s[2:0]),
    .size      (cur_size_s),
    .sign_ext  (cur_sgn_s),
    .wdata     (cur_wdata_s),
    .lo        (lo_in_s),
    .hi        (hi_in_s),
    .split     (split_s),
    .mask16    (mask16_s),
    .wdata_lo  (wdata_lo_s),
    .wdata_hi  (wdata_hi_s),
    .load_data (load_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = accept_s ? ACC1 : IDLE;
      ACC1:    state_nxt_s = split_s ? ACC2 : RESP;
      ACC2:    state_nxt_s = RESP;
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Request and first-half load capture
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_r  <= 32'd0;
      size_r  <= 2'd0;
      sgn_r   <= 1'b0;
      we_r    <= 1'b0;
      err_r   <= 1'b0;
      wdata_r <= 64'd0;
      lo_r    <= 64'd0;
    end else begin
      if (accept_s) begin
        addr_r  <= bus.req_addr;
        size_r  <= bus.req_size;
        sgn_r   <= bus.req_signed;
        we_r    <= bus.req_we;
        wdata_r <= bus.req_wdata;
        err_r   <= range_err_s;
      end
      if (state_r == ACC1) begin
        lo_r <= bus.mem_rdata;
      end
    end
  end

  // Registered outputs, loaded with the values of the state being entered
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_addr_r  <= '0;
      mem_wr_en_r <= 1'b0;
      mem_wmask_r <= 8'd0;
      mem_wdata_r <= 64'd0;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 64'd0;
    end else begin
      mem_wr_en_r <= 1'b0;
      mem_wmask_r <= 8'd0;
      mem_wdata_r <= 64'd0;
      rsp_valid_r <= 1'b0;
      case (state_nxt_s)
        ACC1: begin
          mem_addr_r  <= idx1_s;
          mem_wmask_r <= mask16_s[7:0];
          mem_wdata_r <= wdata_lo_s;
          mem_wr_en_r <= cur_we_s & ~range_err_s;
        end
        ACC2: begin
          mem_addr_r  <= idx2_s;
          mem_wmask_r <= mask16_s[15:8];
          mem_wdata_r <= wdata_hi_s;
          mem_wr_en_r <= we_r & ~err_r;
        end
        RESP: begin
          rsp_valid_r <= 1'b1;
          rsp_err_r   <= err_r;
          rsp_rdata_r <= (we_r | err_r) ? 64'd0 : load_s;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: directed vector table, corner-case
// sequences and random requests against a byte-level reference model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  lsu_mem_master_if #(.ADDR_WID(29)) bus ();

  lsu_mem_master #(.DATA_DEP(512), .ADDR_WID(29)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: dword array, async read, byte-masked write at posedge
  logic [63:0] mem [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = 9'd0;
  logic [63:0] pl_data = 64'd0;
  logic [7:0]  ref_mem [0:4095];

  assign bus.mem_rdata = (bus.mem_addr < 29'd512) ? mem[bus.mem_addr[8:0]] : 64'd0;

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (bus.mem_wr_en && bus.mem_addr < 29'd512) begin
      for (int b = 0; b < 8; b++)
        if (bus.mem_wmask[b]) mem[bus.mem_addr[8:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Reference model: byte-granular view of memory and the access rules
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [1:0] size,
                              input logic sgn, input logic [63:0] wdata,
                              output logic [63:0] rdata, output logic err, output int lat, output int wr);
    int n;
    logic [31:0] a;
    logic [63:0] v;
    n = 1 << size;
    err = 1'b0;
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (a[31:3] >= 29'd512) err = 1'b1;
    end
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 32'(i);
        if (we) ref_mem[a[11:0]] = wdata[8*i +: 8];
        else    v = v | (64'(ref_mem[a[11:0]]) << (8*i));
      end
    end
    if (!we && !err && sgn && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8*n));
    rdata = (we || err) ? 64'd0 : v;
    lat = (int'(addr[2:0]) + n > 8) ? 2 : 1;
    wr = (we && !err) ? lat : 0;
  endtask

  logic [28:0] obs_addr [8];
  logic [7:0]  obs_mask [8];
  logic [63:0] obs_wdata [8];
  logic        obs_we [8];
  int          got_lat, wr_cnt;
  logic [63:0] got_rdata;
  logic        got_err;

  // Issue one request, hold it until the response, record each memory cycle
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sgn, input logic [63:0] wdata);
    int guard;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
    bus.req_size = size; bus.req_signed = sgn; bus.req_wdata = wdata;
    guard = 0;
    while (!bus.req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    got_lat = -1; wr_cnt = 0; got_rdata = 64'd0; got_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      obs_addr[k] = bus.mem_addr; obs_mask[k] = bus.mem_wmask;
      obs_wdata[k] = bus.mem_wdata; obs_we[k] = bus.mem_wr_en;
      if (bus.mem_wr_en) wr_cnt++;
      if (bus.rsp_valid) begin
        got_lat = k; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rsp_pulse", 64'(bus.rsp_valid), 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wr;
  } vec_t;

  vec_t tbl [14];

  initial begin
    logic [63:0] m_rdata, d, old5, old6, exp5;
    logic        m_err, we, sgn;
    int          m_lat, m_wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [28:0] idx2;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'd0;
    bus.req_size = 2'd0; bus.req_signed = 1'b0; bus.req_wdata = 64'd0;

    for (int k = 0; k < 512; k++) begin
      @(negedge clk);
      d = (k == 2) ? 64'h0000_0000_8000_0000 : {$urandom, $urandom};
      pl_en = 1'b1; pl_addr = 9'(k); pl_data = d;
      for (int b = 0; b < 8; b++) ref_mem[k*8+b] = d[8*b +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;

    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 64'd0);
    chk("rst_rsp_err",   64'(bus.rsp_err), 64'd0);
    chk("rst_wr_en",     64'(bus.mem_wr_en), 64'd0);
    chk("rst_wmask",     64'(bus.mem_wmask), 64'd0);
    chk("rst_mem_addr",  64'(bus.mem_addr), 64'd0);
    chk("rst_wdata",     bus.mem_wdata, 64'd0);
    chk("rst_ready",     64'(bus.req_ready), 64'd1);
    @(negedge clk);
    nrst = 1'b1;

    tbl[0]  = '{1'b0, 32'h13,        2'd0, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1, 0};
    tbl[1]  = '{1'b0, 32'h13,        2'd0, 1'b0, 64'd0, 64'h80,                  1'b0, 1, 0};
    tbl[2]  = '{1'b0, 32'h12,        2'd1, 1'b1, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0, 1, 0};
    tbl[3]  = '{1'b0, 32'h10,        2'd2, 1'b0, 64'd0, 64'h8000_0000,           1'b0, 1, 0};
    tbl[4]  = '{1'b0, 32'h10,        2'd2, 1'b1, 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1, 0};
    tbl[5]  = '{1'b0, 32'h10,        2'd3, 1'b1, 64'd0, 64'h8000_0000,           1'b0, 1, 0};
    tbl[6]  = '{1'b0, 32'hFFE,       2'd2, 1'b0, 64'd0, 64'd0,                   1'b1, 2, 0};
    tbl[7]  = '{1'b1, 32'h10,        2'd3, 1'b0, 64'h1122_3344_5566_7788, 64'd0, 1'b0, 1, 1};
    tbl[8]  = '{1'b0, 32'h10,        2'd3, 1'b1, 64'd0, 64'h1122_3344_5566_7788, 1'b0, 1, 0};
    tbl[9]  = '{1'b0, 32'h17,        2'd0, 1'b1, 64'd0, 64'h11,                  1'b0, 1, 0};
    tbl[10] = '{1'b1, 32'h1000,      2'd0, 1'b0, 64'hFF, 64'd0,                  1'b1, 1, 0};
    tbl[11] = '{1'b0, 32'hFFFF_FFF8, 2'd3, 1'b0, 64'd0, 64'd0,                   1'b1, 1, 0};
    tbl[12] = '{1'b1, 32'hFFFF_FFFF, 2'd1, 1'b0, 64'hBEEF, 64'd0,                1'b1, 2, 0};
    tbl[13] = '{1'b1, 32'hFFE,       2'd2, 1'b0, 64'h1234_5678, 64'd0,           1'b1, 2, 0};

    for (int i = 0; i < 14; i++) begin
      model_access(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].wdata, m_rdata, m_err, m_lat, m_wr);
      run_req(tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].sgn, tbl[i].wdata);
      chk("tbl_rdata", got_rdata, tbl[i].exp_rdata);
      chk("tbl_err", 64'(got_err), 64'(tbl[i].exp_err));
      chk("tbl_lat", 64'(got_lat), 64'(tbl[i].exp_lat));
      chk("tbl_wr_cycles", 64'(wr_cnt), 64'(tbl[i].exp_wr));
      chk("tbl_addr1", 64'(obs_addr[0]), 64'(tbl[i].addr[31:3]));
      if (tbl[i].exp_lat == 2) begin
        idx2 = tbl[i].addr[31:3] + 29'd1;
        chk("tbl_addr2", 64'(obs_addr[1]), 64'(idx2));
      end
    end

    // Aligned doubleword store detail
    model_access(1'b1, 32'h10, 2'd3, 1'b0, 64'hA5A5_0102_0304_5A5A, m_rdata, m_err, m_lat, m_wr);
    run_req(1'b1, 32'h10, 2'd3, 1'b0, 64'hA5A5_0102_0304_5A5A);
    chk("sd_mask", 64'(obs_mask[0]), 64'hFF);
    chk("sd_addr", 64'(obs_addr[0]), 64'd2);
    chk("sd_wdata", obs_wdata[0], 64'hA5A5_0102_0304_5A5A);
    chk("sd_we", 64'(obs_we[0]), 64'd1);
    chk("sd_dw2", mem[2], 64'hA5A5_0102_0304_5A5A);

    // Split word store across dwords 1/2
    model_access(1'b1, 32'h0E, 2'd2, 1'b0, 64'hAABB_CCDD, m_rdata, m_err, m_lat, m_wr);
    run_req(1'b1, 32'h0E, 2'd2, 1'b0, 64'hAABB_CCDD);
    chk("sw_lat", 64'(got_lat), 64'd2);
    chk("sw_a1", 64'(obs_addr[0]), 64'd1);
    chk("sw_m1", 64'(obs_mask[0]), 64'hC0);
    chk("sw_d1", 64'(obs_wdata[0][63:48]), 64'hCCDD);
    chk("sw_a2", 64'(obs_addr[1]), 64'd2);
    chk("sw_m2", 64'(obs_mask[1]), 64'h03);
    chk("sw_d2", 64'(obs_wdata[1][15:0]), 64'hAABB);
    chk("sw_we", 64'({obs_we[0], obs_we[1]}), 64'h3);

    // Split doubleword load from dwords 1/2
    d = 64'({mem[2], mem[1]} >> 40);
    model_access(1'b0, 32'h0D, 2'd3, 1'b0, 64'd0, m_rdata, m_err, m_lat, m_wr);
    run_req(1'b0, 32'h0D, 2'd3, 1'b0, 64'd0);
    chk("ld_split", got_rdata, d);
    chk("ld_split_model", got_rdata, m_rdata);
    chk("ld_a1", 64'(obs_addr[0]), 64'd1);
    chk("ld_a2", 64'(obs_addr[1]), 64'd2);

    // Random traffic against the reference model
    for (int r = 0; r < 200; r++) begin
      we = 1'($urandom);
      sgn = 1'($urandom);
      size = 2'($urandom);
      addr = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 4200));
      d = {$urandom, $urandom};
      model_access(we, addr, size, sgn, d, m_rdata, m_err, m_lat, m_wr);
      run_req(we, addr, size, sgn, d);
      chk("rnd_rdata", got_rdata, m_rdata);
      chk("rnd_err", 64'(got_err), 64'(m_err));
      chk("rnd_lat", 64'(got_lat), 64'(m_lat));
      chk("rnd_wr_cycles", 64'(wr_cnt), 64'(m_wr));
    end

    // Reset in the second half of a split store to dwords 5/6
    old5 = mem[5];
    old6 = mem[6];
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 32'h2E;
    bus.req_size = 2'd2; bus.req_signed = 1'b0; bus.req_wdata = 64'h1122_3344;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_acc2_wr", 64'(bus.mem_wr_en), 64'd1);
    chk("rst_acc2_addr", 64'(bus.mem_addr), 64'd6);
    #2;
    nrst = 1'b0;
    #1;
    bus.req_valid = 1'b0;
    chk("rst_async_wr", 64'(bus.mem_wr_en), 64'd0);
    chk("rst_async_ready", 64'(bus.req_ready), 64'd1);
    got_lat = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) got_lat = 1;
    end
    chk("rst_no_rsp", 64'(got_lat), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    exp5 = {16'h3344, old5[47:0]};
    ref_mem[12'h2E] = 8'h44;
    ref_mem[12'h2F] = 8'h33;
    chk("rst_dw5", mem[5], exp5);
    chk("rst_dw6", mem[6], old6);
    @(negedge clk);
    chk("rst_ready_after", 64'(bus.req_ready), 64'd1);

    for (int k = 0; k < 512; k++) begin
      for (int b = 0; b < 8; b++) d[8*b +: 8] = ref_mem[k*8+b];
      chk("mem_image", mem[k], d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
